// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, compare-result encodings and arbiter FSM states shared by the ALU arbiter slice
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SRL  = 4'b0010,
        ALU_SRA  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_UCMP = 4'b1000,
        ALU_SCMP = 4'b1001
    } alu_op_e;

    localparam logic [2:0] GES_GT = 3'b100;
    localparam logic [2:0] GES_EQ = 3'b010;
    localparam logic [2:0] GES_LT = 3'b001;

    typedef logic [1:0] arb_state_e;
    localparam arb_state_e IDLE = 2'd0;
    localparam arb_state_e EXEC = 2'd1;
    localparam arb_state_e RESP = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr, wrapping
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int c;

    // scan N slots starting at ptr; the first hit wins
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int i = 0; i < N; i++) begin
            c = (int'(ptr) + i) % N;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU; ALU_ARBITER_OPCHK_EN rejects opcodes above SCMP
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_arg1,
    input  logic [NUM_REQ*DATA_W-1:0]   req_arg2,
    input  logic [NUM_REQ*OP_W-1:0]     req_op,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]           rsp_result,
    output logic [2:0]                  rsp_ges,
    output logic                        rsp_err,
    output logic [DATA_W-1:0]           Arg1,
    output logic [DATA_W-1:0]           Arg2,
    output logic [OP_W-1:0]             ALU_Control,
    input  logic [DATA_W-1:0]           ALUResult,
    input  logic [2:0]                  GES
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_e          state;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      gnt_idx;
    logic [NUM_REQ-1:0]  gnt;
    logic                gnt_any;
    logic [DATA_W-1:0]   sel_arg1;
    logic [DATA_W-1:0]   sel_arg2;
    logic [OP_W-1:0]     sel_op;
    logic                op_bad;

    rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign sel_arg1  = req_arg1[int'(gnt_idx)*DATA_W +: DATA_W];
    assign sel_arg2  = req_arg2[int'(gnt_idx)*DATA_W +: DATA_W];
    assign sel_op    = req_op[int'(gnt_idx)*OP_W +: OP_W];
    assign req_ready = (rst_n && state == IDLE) ? gnt : '0;
    assign rsp_valid = state == RESP;

`ifdef ALU_ARBITER_OPCHK_EN
    logic rsp_err_q;

    assign op_bad  = sel_op > OP_W'(ALU_SCMP);
    assign rsp_err = rsp_err_q;

    // error flag is decided at grant time and held with the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_err_q <= 1'b0;
        else if (state == IDLE && gnt_any)
            rsp_err_q <= op_bad;
    end
`else
    assign op_bad  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // IDLE grants and drives the ALU, EXEC lets it settle and captures, RESP holds until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_ges     <= '0;
            Arg1        <= '0;
            Arg2        <= '0;
            ALU_Control <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_any) begin
                    rsp_id <= gnt_idx;
                    if (op_bad) begin
                        rsp_result <= '0;
                        rsp_ges    <= '0;
                        state      <= RESP;
                    end else begin
                        Arg1        <= sel_arg1;
                        Arg2        <= sel_arg2;
                        ALU_Control <= sel_op;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= ALUResult;
                    rsp_ges    <= GES;
                    state      <= RESP;
                end
                RESP: if (rsp_ready) begin
                    state  <= IDLE;
                    rr_ptr <= (int'(rsp_id) == NUM_REQ - 1) ? '0 : rsp_id + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
